serialize: RTL and testbench

SERIALIZE -- requirements
Module: serialize

---
 rtl/serialize.sv | 105 ++++++++++
 tb/tb_serialize.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/serialize.sv
// Purpose : splits one NUM-lane input word into NUM consecutive W_LANE-bit output lanes, LSB lane first.
// Latency : lane 0 appears on dout the cycle after the din handshake; one lane per cycle afterwards.
// Backpress: dout_ready_i low holds the current lane; din_ready_o is high in IDLE or in the last-lane handshake cycle.
//
// Ports:
//   clk_i        - single clock, all state on its rising edge
//   rst_ni       - asynchronous active-low reset
//   din_data_i   - input word, lane k = din_data_i[k*W_LANE +: W_LANE]
//   din_valid_i  - input word valid
//   din_ready_o  - input word ready (never depends on din_valid_i)
//   dout_data_o  - {eot, lane}; eot marks the last lane of a word
//   dout_valid_o - output lane valid
//   dout_ready_i - output lane ready
module serialize #(
  parameter int W_LANE = 8,
  parameter int NUM    = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM*W_LANE-1:0]   din_data_i,
  input  logic                    din_valid_i,
  output logic                    din_ready_o,
  output logic [W_LANE:0]         dout_data_o,
  output logic                    dout_valid_o,
  input  logic                    dout_ready_i
);

  localparam int CNT_W = $clog2(NUM);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(NUM - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM*W_LANE-1:0]   word_q, word_d;

  logic [W_LANE-1:0]       lanes [NUM];
  logic                    is_last;

  for (genvar k = 0; k < NUM; k++) begin : g_lanes
    assign lanes[k] = word_q[k*W_LANE +: W_LANE];
  end

  assign is_last     = (cnt_q == LAST_LANE);
  // The lane mux is driven from registers only, so the output stays stable under backpressure.
  assign dout_data_o = {is_last, lanes[cnt_q]};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    word_d       = word_q;
    din_ready_o  = 1'b0;
    dout_valid_o = 1'b0;

    case (state_q)
      IDLE: begin
        din_ready_o = 1'b1;
        if (din_valid_i) begin
          word_d  = din_data_i;
          cnt_d   = '0;
          state_d = SEND;
        end
      end

      SEND: begin
        dout_valid_o = 1'b1;
        if (dout_ready_i) begin
          if (is_last) begin
            // Last lane leaves this cycle, so the word register frees up now:
            // accept a follow-on word without a bubble.
            din_ready_o = 1'b1;
            if (din_valid_i) begin
              word_d = din_data_i;
              cnt_d  = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
    end
  end

endmodule

// File: tb/tb_serialize.sv
// Purpose : scoreboard bench for serialize (NUM=4, W_LANE=8).
// Latency : n/a (testbench).
// Backpress: drives directed and random valid/ready patterns.
module tb_serialize;

  localparam int W   = 8;
  localparam int NUM = 4;
  localparam int N_RANDOM_WORDS = 10000;

  logic                 clk;
  logic                 rst_n;
  logic [NUM*W-1:0]     din_data;
  logic                 din_valid;
  logic                 din_ready;
  logic [W:0]           dout_data;
  logic                 dout_valid;
  logic                 dout_ready;

  int n_chk  = 0;
  int n_pass = 0;

  logic [W:0] exp_q [$];

  serialize #(.W_LANE(W), .NUM(NUM)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .din_data_i  (din_data),
    .din_valid_i (din_valid),
    .din_ready_o (din_ready),
    .dout_data_o (dout_data),
    .dout_valid_o(dout_valid),
    .dout_ready_i(dout_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Input side of the scoreboard: every accepted word expands into NUM expected lanes.
  always @(negedge clk) begin
    if (rst_n && din_valid && din_ready) begin
      for (int k = 0; k < NUM; k++)
        exp_q.push_back({(k == NUM-1) ? 1'b1 : 1'b0, din_data[k*W +: W]});
    end
  end

  // Output monitor: compares each transferred lane and checks stability while stalled.
  logic       prev_stall = 1'b0;
  logic [W:0] prev_dat   = '0;
  always @(negedge clk) begin
    logic [31:0] expv;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (dout_valid) begin
        if (prev_stall) chk("hold_stable", {23'd0, dout_data}, {23'd0, prev_dat});
        if (dout_ready) begin
          expv = (exp_q.size() > 0) ? {23'd0, exp_q.pop_front()} : 32'hDEAD0000;
          chk("lane", {23'd0, dout_data}, expv);
        end
      end
      prev_stall = dout_valid && !dout_ready;
      prev_dat   = dout_data;
    end
  end

  // Runs a 10-cycle directed window from IDLE with dout_ready=1 and checks per-cycle
  // din_ready, dout_valid and eot against hand-derived bit patterns (bit c = cycle c).
  task automatic directed_seq(input string tag, input int nwords,
                              input logic [31:0] w0, input logic [31:0] w1,
                              input logic [9:0] exp_rdy, input logic [9:0] exp_vld,
                              input logic [9:0] exp_eot);
    int   idx = 0;
    logic hs;
    din_valid  = 1'b1;
    din_data   = w0;
    dout_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk({tag, "_din_ready"}, {31'd0, din_ready}, {31'd0, exp_rdy[c]});
      chk({tag, "_dout_valid"}, {31'd0, dout_valid}, {31'd0, exp_vld[c]});
      if (exp_vld[c]) chk({tag, "_eot"}, {31'd0, dout_data[W]}, {31'd0, exp_eot[c]});
      hs = din_valid && din_ready;
      @(posedge clk); #1;
      if (hs) begin
        idx++;
        if (idx < nwords) din_data = w1;
        else din_valid = 1'b0;
      end
    end
  endtask

  initial begin
    int   sent;
    int   cyc;
    logic hs;

    rst_n      = 1'b0;
    din_valid  = 1'b0;
    din_data   = '0;
    dout_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout_valid", {31'd0, dout_valid}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_din_ready", {31'd0, din_ready}, 32'd1);
    chk("rst_dout_valid_post", {31'd0, dout_valid}, 32'd0);
    @(posedge clk); #1;

    // Single word then idle gap: lanes on cycles 1..4, eot on cycle 4, IDLE from cycle 5
    directed_seq("single", 1, 32'h44332211, 32'h0,
                 10'b1111110001, 10'b0000011110, 10'b0000010000);

    // Back-to-back: eight transfers cycles 1..8, din_ready only on cycles 0, 4, 8 (and 9 idle)
    directed_seq("b2b", 2, 32'h44332211, 32'h88776655,
                 10'b1100010001, 10'b0111111110, 10'b0100010000);

    // Backpressure at lane 2 for three cycles
    din_valid  = 1'b1;
    din_data   = 32'h44332211;
    dout_ready = 1'b1;
    @(negedge clk);
    chk("bp_accept", {31'd0, din_ready}, 32'd1);
    @(posedge clk); #1;
    din_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    dout_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, dout_valid}, 32'd1);
      chk("bp_data", {23'd0, dout_data}, 32'h033);
      chk("bp_din_ready", {31'd0, din_ready}, 32'd0);
    end
    @(posedge clk); #1;
    dout_ready = 1'b1;
    @(negedge clk);
    chk("bp_resume_lane2", {23'd0, dout_data}, 32'h033);
    @(negedge clk);
    chk("bp_resume_lane3", {23'd0, dout_data}, 32'h144);
    repeat (3) @(posedge clk);
    #1;

    // Reset mid-word after lane 1 has transferred
    din_valid = 1'b1;
    din_data  = 32'h44332211;
    @(negedge clk);
    @(posedge clk); #1;
    din_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_dout_valid", {31'd0, dout_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_din_ready", {31'd0, din_ready}, 32'd1);
    chk("midrst_idle", {31'd0, dout_valid}, 32'd0);
    @(posedge clk); #1;
    din_valid = 1'b1;
    din_data  = 32'hDDCCBBAA;
    @(negedge clk);
    @(posedge clk); #1;
    din_valid = 1'b0;
    @(negedge clk);
    chk("midrst_first_valid", {31'd0, dout_valid}, 32'd1);
    chk("midrst_first_lane", {23'd0, dout_data}, 32'h0AA);
    repeat (6) @(posedge clk);
    #1;
    chk("directed_drain", exp_q.size(), 32'd0);

    // Random valid/ready against the scoreboard
    sent = 0;
    cyc  = 0;
    din_valid = 1'b0;
    while (sent < N_RANDOM_WORDS && cyc < 80000) begin
      @(negedge clk);
      hs = din_valid && din_ready;
      @(posedge clk); #1;
      cyc++;
      if (hs) begin
        sent++;
        din_valid = 1'b0;
      end
      if (!din_valid && sent < N_RANDOM_WORDS && $urandom_range(0, 7) != 0) begin
        din_valid = 1'b1;
        din_data  = $urandom;
      end
      dout_ready = ($urandom_range(0, 3) != 0);
    end
    chk("random_words_sent", sent, N_RANDOM_WORDS);
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    chk("random_drain", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
